// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: port owner and arbiter state,
// plus the round-robin winner selection used in IDLE.
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_GFX,
        OWNER_HOST
    } owner_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    localparam logic [3:0] VRAM_MASK_ALL = 4'hF;

    // A lone requester wins outright; on contention the requester that did
    // not own the port last time goes first.
    function automatic owner_t pick_winner(input logic   gfx_req,
                                           input logic   host_req,
                                           input owner_t last_owner);
        owner_t win;
        win = OWNER_NONE;
        if (gfx_req && host_req)
            win = (last_owner == OWNER_GFX) ? OWNER_HOST : OWNER_GFX;
        else if (gfx_req)
            win = OWNER_GFX;
        else if (host_req)
            win = OWNER_HOST;
        return win;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Two-requester VRAM port arbiter (rasterizer write-only, host read/write)
// with round-robin on contention and an abort watchdog for lost acks.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_ni,

    input  logic                  gfx_sel_i,
    input  logic [3:0]            gfx_mask_i,
    input  logic [ADDR_WIDTH-1:0] gfx_addr_i,
    input  logic [DATA_WIDTH-1:0] gfx_data_i,
    output logic                  gfx_ack_o,

    input  logic                  host_sel_i,
    input  logic                  host_wr_i,
    input  logic [3:0]            host_mask_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_data_i,
    output logic [DATA_WIDTH-1:0] host_data_o,
    output logic                  host_ack_o,

    output logic                  vram_sel_o,
    output logic                  vram_wr_o,
    output logic [3:0]            vram_mask_o,
    output logic [ADDR_WIDTH-1:0] vram_addr_o,
    output logic [DATA_WIDTH-1:0] vram_data_out_o,
    input  logic [DATA_WIDTH-1:0] vram_data_in_i,
    input  logic                  vram_ack_i,

    output logic                  timeout_o
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t      state;
    owner_t          owner;
    owner_t          last_owner;
    owner_t          winner;
    logic [WD_W-1:0] watchdog;
    logic            busy;
    logic            expire;
    logic            done;

    assign busy   = (state == ARB_BUSY);
    // A real ack on the expiry cycle wins, so timeout_o is not raised then.
    assign expire = busy && !vram_ack_i && (TIMEOUT_CYCLES != 0) &&
                    (watchdog == WD_W'(TIMEOUT_CYCLES));
    assign done   = busy && (vram_ack_i || expire);

    always_comb winner = pick_winner(gfx_sel_i, host_sel_i, last_owner);

    // Acks are combinational so the owner sees completion in the same cycle
    // VRAM acks; gating with busy makes stray IDLE acks invisible.
    assign gfx_ack_o   = done && (owner == OWNER_GFX);
    assign host_ack_o  = done && (owner == OWNER_HOST);
    assign host_data_o = (host_ack_o && vram_ack_i) ? vram_data_in_i : '0;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain updates.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state           <= ARB_IDLE;
            owner           <= OWNER_NONE;
            last_owner      <= OWNER_HOST;
            watchdog        <= '0;
            vram_sel_o      <= 1'b0;
            vram_wr_o       <= 1'b0;
            vram_mask_o     <= '0;
            vram_addr_o     <= '0;
            vram_data_out_o <= '0;
            timeout_o       <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (winner != OWNER_NONE) begin
                        state      <= ARB_BUSY;
                        owner      <= winner;
                        watchdog   <= '0;
                        vram_sel_o <= 1'b1;
                        if (winner == OWNER_GFX) begin
                            vram_wr_o       <= 1'b1;
                            vram_mask_o     <= gfx_mask_i;
                            vram_addr_o     <= gfx_addr_i;
                            vram_data_out_o <= gfx_data_i;
                        end else begin
                            vram_wr_o       <= host_wr_i;
                            vram_mask_o     <= host_mask_i;
                            vram_addr_o     <= host_addr_i;
                            vram_data_out_o <= host_data_i;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (done) begin
                        state      <= ARB_IDLE;
                        last_owner <= owner;
                        owner      <= OWNER_NONE;
                        vram_sel_o <= 1'b0;
                        vram_wr_o  <= 1'b0;
                        if (expire)
                            timeout_o <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (watchdog shortened to 8).
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          gfx_sel_i, host_sel_i, host_wr_i, vram_ack_i;
    logic [3:0]    gfx_mask_i, host_mask_i;
    logic [AW-1:0] gfx_addr_i, host_addr_i;
    logic [DW-1:0] gfx_data_i, host_data_i, vram_data_in_i;
    logic          gfx_ack_o, host_ack_o, vram_sel_o, vram_wr_o, timeout_o;
    logic [3:0]    vram_mask_o;
    logic [AW-1:0] vram_addr_o;
    logic [DW-1:0] vram_data_out_o, host_data_o;

    int n_cmp  = 0;
    int n_fail = 0;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_ni(reset_ni),
        .gfx_sel_i(gfx_sel_i), .gfx_mask_i(gfx_mask_i), .gfx_addr_i(gfx_addr_i),
        .gfx_data_i(gfx_data_i), .gfx_ack_o(gfx_ack_o),
        .host_sel_i(host_sel_i), .host_wr_i(host_wr_i), .host_mask_i(host_mask_i),
        .host_addr_i(host_addr_i), .host_data_i(host_data_i),
        .host_data_o(host_data_o), .host_ack_o(host_ack_o),
        .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
        .vram_addr_o(vram_addr_o), .vram_data_out_o(vram_data_out_o),
        .vram_data_in_i(vram_data_in_i), .vram_ack_i(vram_ack_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int ack_cycle;

        reset_ni = 1'b0;
        gfx_sel_i = 0; host_sel_i = 0; host_wr_i = 0; vram_ack_i = 0;
        gfx_mask_i = '0; host_mask_i = '0; gfx_addr_i = '0; host_addr_i = '0;
        gfx_data_i = '0; host_data_i = '0; vram_data_in_i = '0;

        // Reset state
        #2;
        check("rst_sel",     vram_sel_o, 0);
        check("rst_wr",      vram_wr_o, 0);
        check("rst_mask",    vram_mask_o, 0);
        check("rst_addr",    vram_addr_o, 0);
        check("rst_dout",    vram_data_out_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_gfx_ack", gfx_ack_o, 0);
        check("rst_host_ack", host_ack_o, 0);
        step(); step();
        reset_ni = 1'b1;
        step();

        // Stray ack while IDLE
        vram_ack_i = 1; vram_data_in_i = 16'h1234;
        #1;
        check("stray_gfx_ack",  gfx_ack_o, 0);
        check("stray_host_ack", host_ack_o, 0);
        check("stray_host_data", host_data_o, 0);
        step();
        vram_ack_i = 0; vram_data_in_i = '0;
        check("stray_sel", vram_sel_o, 0);

        // Single gfx write, ack three cycles after grant
        gfx_sel_i = 1; gfx_addr_i = 16'h0123; gfx_data_i = 16'hF0A5; gfx_mask_i = VRAM_MASK_ALL;
        #1;
        check("gfx_sel_latency", vram_sel_o, 0);
        step();
        check("gfx_sel",  vram_sel_o, 1);
        check("gfx_wr",   vram_wr_o, 1);
        check("gfx_addr", vram_addr_o, 16'h0123);
        check("gfx_data", vram_data_out_o, 16'hF0A5);
        check("gfx_mask", vram_mask_o, 4'hF);
        check("gfx_noack0", gfx_ack_o, 0);
        step();
        check("gfx_noack1", gfx_ack_o, 0);
        step();
        check("gfx_noack2", gfx_ack_o, 0);
        check("gfx_hold_sel", vram_sel_o, 1);
        step();
        vram_ack_i = 1;
        #1;
        check("gfx_ack",         gfx_ack_o, 1);
        check("gfx_ack_no_host", host_ack_o, 0);
        step();
        vram_ack_i = 0; gfx_sel_i = 0;
        #1;
        check("gfx_sel_drop", vram_sel_o, 0);
        check("gfx_ack_once", gfx_ack_o, 0);

        // Host read
        host_sel_i = 1; host_wr_i = 0; host_addr_i = 16'h0040;
        host_data_i = 16'h5555; host_mask_i = 4'h3;
        step();
        check("rd_sel",  vram_sel_o, 1);
        check("rd_wr",   vram_wr_o, 0);
        check("rd_addr", vram_addr_o, 16'h0040);
        step();
        vram_ack_i = 1; vram_data_in_i = 16'hBEEF;
        #1;
        check("rd_ack",    host_ack_o, 1);
        check("rd_data",   host_data_o, 16'hBEEF);
        check("rd_no_gfx", gfx_ack_o, 0);
        check("rd_wr_ack", vram_wr_o, 0);
        step();
        vram_ack_i = 0; vram_data_in_i = '0; host_sel_i = 0;
        #1;
        check("rd_ack_off",  host_ack_o, 0);
        check("rd_data_off", host_data_o, 0);

        // Contention: both held, immediate ack -> GFX HOST GFX HOST
        gfx_sel_i = 1; gfx_addr_i = 16'h1111; gfx_data_i = 16'hAAAA;
        host_sel_i = 1; host_wr_i = 1; host_addr_i = 16'h2222; host_data_i = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr%0d_sel", i),  vram_sel_o, 1);
            check($sformatf("rr%0d_addr", i), vram_addr_o, (i % 2 == 0) ? 16'h1111 : 16'h2222);
            check($sformatf("rr%0d_wr", i),   vram_wr_o, 1);
            vram_ack_i = 1;
            #1;
            check($sformatf("rr%0d_gfx_ack", i),  gfx_ack_o,  (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_host_ack", i), host_ack_o, (i % 2 == 0) ? 0 : 1);
            step();
            vram_ack_i = 0;
            if (i == 3) begin
                gfx_sel_i = 0; host_sel_i = 0;
            end
            check($sformatf("rr%0d_bubble", i), vram_sel_o, 0);
        end
        step();
        check("rr_idle", vram_sel_o, 0);

        // Watchdog: host write never acked
        host_sel_i = 1; host_wr_i = 1; host_addr_i = 16'h3333; host_data_i = 16'h7777;
        seen = 0; ack_cycle = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (host_ack_o) begin
                seen = 1;
                ack_cycle = k;
                check("wd_data_zero", host_data_o, 0);
                check("wd_no_gfx", gfx_ack_o, 0);
                check("wd_timeout_pre", timeout_o, 0);
                host_sel_i = 0;
            end
        end
        check("wd_seen", seen, 1);
        check("wd_cycle", ack_cycle, 9);
        step();
        check("wd_timeout", timeout_o, 1);
        check("wd_sel_drop", vram_sel_o, 0);
        check("wd_ack_once", host_ack_o, 0);

        // Normal gfx write after timeout
        gfx_sel_i = 1; gfx_addr_i = 16'h4444; gfx_data_i = 16'h0F0F;
        step();
        check("post_wd_sel",  vram_sel_o, 1);
        check("post_wd_addr", vram_addr_o, 16'h4444);
        vram_ack_i = 1;
        #1;
        check("post_wd_ack", gfx_ack_o, 1);
        step();
        vram_ack_i = 0; gfx_sel_i = 0;
        check("post_wd_sticky", timeout_o, 1);
        check("post_wd_drop", vram_sel_o, 0);

        // Asynchronous reset in the middle of a BUSY access
        host_sel_i = 1; host_wr_i = 0; host_addr_i = 16'h5555;
        step();
        check("mid_busy_sel", vram_sel_o, 1);
        #2;
        vram_ack_i = 1; vram_data_in_i = 16'hDEAD;
        reset_ni = 0;
        #1;
        check("arst_sel",      vram_sel_o, 0);
        check("arst_addr",     vram_addr_o, 0);
        check("arst_host_ack", host_ack_o, 0);
        check("arst_gfx_ack",  gfx_ack_o, 0);
        check("arst_data",     host_data_o, 0);
        check("arst_timeout",  timeout_o, 0);
        vram_ack_i = 0; vram_data_in_i = '0; host_sel_i = 0;
        step();
        reset_ni = 1;
        step();
        gfx_sel_i = 1; gfx_addr_i = 16'h6666; gfx_data_i = 16'h1357;
        #1;
        check("rel_latency", vram_sel_o, 0);
        step();
        check("rel_sel",  vram_sel_o, 1);
        check("rel_addr", vram_addr_o, 16'h6666);
        vram_ack_i = 1;
        #1;
        check("rel_ack", gfx_ack_o, 1);
        step();
        vram_ack_i = 0; gfx_sel_i = 0;
        check("rel_drop", vram_sel_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
